fetch_p1: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the 16-bit SIMPLE pipeline. Holds the program counter, drives the instruction memory address, and captures the fetched instruction and its PC+1 into the IF/ID register that feeds decode. It obeys the stall, flush and branch controls that decode's hazard and control units return.

---
 rtl/simple_pkg.sv | 12 +
 rtl/fetch_p1_program_counter.sv | 31 +++
 rtl/fetch_p1.sv | 86 ++++++++
 tb/tb_fetch_p1.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared constants for the SIMPLE 16-bit pipeline: default widths, reset PC
// and the NOP encoding that decode recognises as a pure bubble.
package simple_pkg;

    localparam int          ADDR_WIDTH_DEF  = 16;
    localparam int          DATA_WIDTH_DEF  = 16;
    localparam logic [15:0] RESET_PC_DEF    = 16'h0000;

    // No register write, no memory access, no branch, no condition-code write.
    localparam logic [15:0] NOP_INSTRUCTION = 16'b11_000_000_1110_0000;

endpackage

// File: rtl/fetch_p1_program_counter.sv
// PC register with next-PC mux and incrementer. pc_inc is exported so the
// IF/ID register can capture PC+1 without a second adder.
module program_counter
    import simple_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  branch_sel,
    input  logic [ADDR_WIDTH-1:0] branch_address,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_inc
);

    logic [ADDR_WIDTH-1:0] pc_next;

    // Wraps silently at the top of the address space.
    assign pc_inc  = pc + ADDR_WIDTH'(1);
    assign pc_next = branch_sel ? branch_address : pc_inc;

    always_ff @(posedge clock) begin
        if (reset)
            pc <= RESET_PC;
        else if (write_en)
            pc <= pc_next;
    end

endmodule

// File: rtl/fetch_p1.sv
// Fetch stage plus IF/ID register. Optional FETCH_PERF_EN adds fetch and
// bubble counters as extra output ports.
module fetch_p1
    import simple_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
    input  logic                  op_pc_write,
    input  logic                  op_if_id_write,
    input  logic                  op_if_id_flush,
    input  logic                  op_branch,
    input  logic [ADDR_WIDTH-1:0] branch_address,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instruction_register,
    output logic [ADDR_WIDTH-1:0] program_counter_pre
`ifdef FETCH_PERF_EN
   ,output logic [15:0]           fetch_count,
    output logic [15:0]           bubble_count
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTRUCTION);

    logic [ADDR_WIDTH-1:0] pc_inc;

    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clock          (clock),
        .reset          (reset),
        .write_en       (exec & op_pc_write),
        .branch_sel     (op_branch),
        .branch_address (branch_address),
        .pc             (pc),
        .pc_inc         (pc_inc)
    );

    assign imem_address = pc;

    // Flush beats a held IF/ID so a taken branch always leaves one bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            instruction_register <= NOP;
            program_counter_pre  <= '0;
        end else if (exec) begin
            if (op_if_id_flush) begin
                instruction_register <= NOP;
                program_counter_pre  <= pc_inc;
            end else if (op_if_id_write) begin
                instruction_register <= imem_data;
                program_counter_pre  <= pc_inc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic load_fetch;
    logic load_bubble;

    assign load_fetch  = exec & ~op_if_id_flush & op_if_id_write;
    assign load_bubble = exec & op_if_id_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (load_fetch)
                fetch_count <= fetch_count + 16'd1;
            if (load_bubble)
                bubble_count <= bubble_count + 16'd1;
        end
    end
`else
    // Counters compiled out; the fetch path is unchanged.
`endif

endmodule

// File: tb/tb_fetch_p1.sv
// Directed bench for fetch_p1: a vector table walks through run, stall, branch,
// flush-during-hold, freeze and reset-mid-stall; a second instance covers PC wrap.
module tb_fetch_p1;
    import simple_pkg::*;

    logic        clock = 1'b0;
    logic        reset, exec, op_pc_write, op_if_id_write, op_if_id_flush, op_branch;
    logic [15:0] branch_address;
    logic [15:0] imem_data, imem_address, pc, instruction_register, program_counter_pre;

    logic        exec_w;
    logic [15:0] imem_data_w, imem_address_w, pc_w, ir_w, pre_w;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count, bubble_count, fetch_count_w, bubble_count_w;
`endif

    always #5 clock = ~clock;

    // Instruction memory model: word at address a is A000+a.
    assign imem_data   = 16'hA000 + imem_address;
    assign imem_data_w = 16'hA000 + imem_address_w;

    fetch_p1 dut (
        .clock                (clock),
        .reset                (reset),
        .exec                 (exec),
        .op_pc_write          (op_pc_write),
        .op_if_id_write       (op_if_id_write),
        .op_if_id_flush       (op_if_id_flush),
        .op_branch            (op_branch),
        .branch_address       (branch_address),
        .imem_data            (imem_data),
        .imem_address         (imem_address),
        .pc                   (pc),
        .instruction_register (instruction_register),
        .program_counter_pre  (program_counter_pre)
`ifdef FETCH_PERF_EN
       ,.fetch_count          (fetch_count),
        .bubble_count         (bubble_count)
`endif
    );

    fetch_p1 #(.RESET_PC(16'hFFFF)) u_wrap (
        .clock                (clock),
        .reset                (reset),
        .exec                 (exec_w),
        .op_pc_write          (1'b1),
        .op_if_id_write       (1'b1),
        .op_if_id_flush       (1'b0),
        .op_branch            (1'b0),
        .branch_address       (16'h0000),
        .imem_data            (imem_data_w),
        .imem_address         (imem_address_w),
        .pc                   (pc_w),
        .instruction_register (ir_w),
        .program_counter_pre  (pre_w)
`ifdef FETCH_PERF_EN
       ,.fetch_count          (fetch_count_w),
        .bubble_count         (bubble_count_w)
`endif
    );

    typedef struct {
        logic        rst, ex, pcw, ifw, fl, br;
        logic [15:0] baddr;
        logic [15:0] e_pc, e_ir, e_pre, e_fc, e_bc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    localparam logic [15:0] NOP = NOP_INSTRUCTION;
    localparam int NV = 20;
    vec_t v [NV];

    initial begin
        //        rst  ex   pcw  ifw  fl   br   baddr    pc       ir       pre      fc  bc
        v[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0001,16'hA000,16'h0001,16'd1,16'd0};
        v[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0002,16'hA001,16'h0002,16'd2,16'd0};
        v[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0003,16'hA002,16'h0003,16'd3,16'd0};
        v[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0004,16'hA003,16'h0004,16'd4,16'd0};
        v[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0005,16'hA004,16'h0005,16'd5,16'd0};
        // stall two cycles at pc=0005
        v[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0005,16'hA004,16'h0005,16'd5,16'd0};
        v[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0005,16'hA004,16'h0005,16'd5,16'd0};
        v[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0006,16'hA005,16'h0006,16'd6,16'd0};
        v[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0007,16'hA006,16'h0007,16'd7,16'd0};
        // taken branch at pc=0007 to 0040
        v[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,16'h0040,16'h0040,NOP,     16'h0008,16'd7,16'd1};
        v[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0041,16'hA040,16'h0041,16'd8,16'd1};
        // flush while IF/ID write is low
        v[11] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,16'h0000,16'h0042,NOP,     16'h0042,16'd8,16'd2};
        // branch requested but PC write low: pc holds
        v[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,16'h0100,16'h0042,16'hA042,16'h0043,16'd9,16'd2};
        // exec low for 3 cycles with every other control active
        v[13] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,16'h0200,16'h0042,16'hA042,16'h0043,16'd9,16'd2};
        v[14] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,16'h0200,16'h0042,16'hA042,16'h0043,16'd9,16'd2};
        v[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0042,16'hA042,16'h0043,16'd9,16'd2};
        v[16] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0043,16'hA042,16'h0043,16'd10,16'd2};
        // jump to 0123, stall there, then reset mid-stall
        v[17] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,16'h0123,16'h0123,NOP,     16'h0044,16'd10,16'd3};
        v[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0123,NOP,     16'h0044,16'd10,16'd3};
        v[19] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,16'h0040,16'h0000,NOP,     16'h0000,16'd0,16'd0};

        reset = 1'b1; exec = 1'b0; exec_w = 1'b0;
        op_pc_write = 1'b0; op_if_id_write = 1'b0; op_if_id_flush = 1'b0;
        op_branch = 1'b0; branch_address = 16'h0000;
        step();
        chk("reset_pc",     pc,                   16'h0000);
        chk("reset_imem",   imem_address,         16'h0000);
        chk("reset_ir",     instruction_register, NOP);
        chk("reset_pre",    program_counter_pre,  16'h0000);
        chk("wrap_rst_pc",  pc_w,                 16'hFFFF);
        chk("wrap_rst_ir",  ir_w,                 NOP);
`ifdef FETCH_PERF_EN
        chk("reset_fc",     fetch_count,          16'd0);
        chk("reset_bc",     bubble_count,         16'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            reset = v[i].rst; exec = v[i].ex; op_pc_write = v[i].pcw;
            op_if_id_write = v[i].ifw; op_if_id_flush = v[i].fl;
            op_branch = v[i].br; branch_address = v[i].baddr;
            step();
            chk($sformatf("v%0d_pc", i),   pc,                   v[i].e_pc);
            chk($sformatf("v%0d_imem", i), imem_address,         v[i].e_pc);
            chk($sformatf("v%0d_ir", i),   instruction_register, v[i].e_ir);
            chk($sformatf("v%0d_pre", i),  program_counter_pre,  v[i].e_pre);
`ifdef FETCH_PERF_EN
            chk($sformatf("v%0d_fc", i),   fetch_count,          v[i].e_fc);
            chk($sformatf("v%0d_bc", i),   bubble_count,         v[i].e_bc);
`endif
        end

        // Wrap instance: still at FFFF after the table's reset, then one fetch.
        reset = 1'b0; exec = 1'b0; op_branch = 1'b0; op_if_id_flush = 1'b0;
        chk("wrap_hold_pc", pc_w, 16'hFFFF);
        exec_w = 1'b1;
        step();
        chk("wrap_pc",  pc_w,  16'h0000);
        chk("wrap_ir",  ir_w,  16'h9FFF);
        chk("wrap_pre", pre_w, 16'h0000);
        exec_w = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("frz%0d_pc", k),  pc_w,  16'h0000);
            chk($sformatf("frz%0d_ir", k),  ir_w,  16'h9FFF);
            chk($sformatf("frz%0d_pre", k), pre_w, 16'h0000);
`ifdef FETCH_PERF_EN
            chk($sformatf("frz%0d_fc", k),  fetch_count_w,  16'd1);
            chk($sformatf("frz%0d_bc", k),  bubble_count_w, 16'd0);
`endif
        end
        // Main DUT stayed frozen in reset state while exec was low.
        chk("main_frozen_pc", pc, 16'h0000);
        chk("main_frozen_ir", instruction_register, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
